// File: rtl/mips_bus_monitor.sv
// Run monitor for a MIPS core under test: sequences the CPU reset, polices every
// bus access during the run and reports either a clean finish or the first failure cause.
module mips_bus_monitor #(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned RESET_CYCLES   = 1,
  parameter int unsigned ACTIVE_WAIT    = 1,
  parameter logic [31:0] WIN0_BASE      = 32'hBFC00000,
  parameter logic [31:0] WIN0_SIZE      = 32'h00008000,
  parameter logic [31:0] WIN1_BASE      = 32'h00000000,
  parameter logic [31:0] WIN1_SIZE      = 32'h00000000,
  parameter bit          ALLOW_NULL     = 1'b1,
  parameter int unsigned MAX_STALL      = 64,
  parameter bit          CHECK_V0       = 1'b0,
  parameter logic [31:0] EXPECT_V0      = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        cpu_reset,
  input  logic        active,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic        waitrequest,
  input  logic [3:0]  byteenable,
  input  logic [31:0] register_v0,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic [2:0]  err_code,
  output logic [31:0] err_addr,
  output logic [31:0] cycle_count,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count,
  output logic [31:0] result_v0
);

  typedef enum logic [2:0] {
    ST_RST_SEQ, ST_WAIT_ACT, ST_RUN, ST_DONE, ST_FAIL
  } state_e;

  state_e      state_q;
  logic [31:0] seq_cnt_q;
  logic [31:0] stall_q;
  logic [31:0] addr_prev_q;
  logic        cpu_reset_q, done_q, pass_q, fail_q;
  logic [2:0]  err_code_q;
  logic [31:0] err_addr_q, cycle_count_q, result_v0_q;
  logic [15:0] rd_q, wr_q;

  logic        access, in_win0, in_win1, legal, stall_err, timeout, v0_bad;
  logic [31:0] off0, off1, cycle_count_d;
  logic [2:0]  run_err_d;

  always_comb begin
    access        = read | write;
    // Offset compare handles the inclusive upper bound without 33-bit arithmetic.
    off0          = address - WIN0_BASE;
    off1          = address - WIN1_BASE;
    in_win0       = off0 < WIN0_SIZE;
    in_win1       = (WIN1_SIZE != 32'd0) && (off1 < WIN1_SIZE);
    legal         = in_win0 || in_win1 || (ALLOW_NULL && (address == 32'd0));
    cycle_count_d = cycle_count_q + 32'd1;
    stall_err     = (access && waitrequest && (stall_q == MAX_STALL)) ||
                    ((stall_q != 32'd0) && (!access || (address != addr_prev_q)));
    timeout       = active && (cycle_count_d == TIMEOUT_CYCLES);
    v0_bad        = !active && CHECK_V0 && (register_v0 != EXPECT_V0);
    run_err_d     = 3'd0;
    if (access && !legal)                    run_err_d = 3'd2;
    else if (read && write)                  run_err_d = 3'd3;
    else if (access && byteenable == 4'd0)   run_err_d = 3'd4;
    else if (stall_err)                      run_err_d = 3'd5;
    else if (timeout)                        run_err_d = 3'd6;
    else if (v0_bad)                         run_err_d = 3'd7;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_RST_SEQ;
      seq_cnt_q     <= '0;
      stall_q       <= '0;
      addr_prev_q   <= '0;
      cpu_reset_q   <= 1'b1;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_q        <= 1'b0;
      err_code_q    <= '0;
      err_addr_q    <= '0;
      cycle_count_q <= '0;
      rd_q          <= '0;
      wr_q          <= '0;
      result_v0_q   <= '0;
    end else begin
      case (state_q)
        ST_RST_SEQ: begin
          if (seq_cnt_q + 32'd1 >= RESET_CYCLES) begin
            state_q     <= ST_WAIT_ACT;
            cpu_reset_q <= 1'b0;
            seq_cnt_q   <= '0;
          end else begin
            seq_cnt_q <= seq_cnt_q + 32'd1;
          end
        end
        // The core may leave active low for ACTIVE_WAIT cycles; one more low cycle fails.
        ST_WAIT_ACT: begin
          if (active) begin
            state_q <= ST_RUN;
          end else if (seq_cnt_q >= ACTIVE_WAIT) begin
            state_q    <= ST_FAIL;
            done_q     <= 1'b1;
            fail_q     <= 1'b1;
            err_code_q <= 3'd1;
            err_addr_q <= address;
          end else begin
            seq_cnt_q <= seq_cnt_q + 32'd1;
          end
        end
        ST_RUN: begin
          cycle_count_q <= cycle_count_d;
          if (read && !waitrequest && rd_q != 16'hFFFF)  rd_q <= rd_q + 16'd1;
          if (write && !waitrequest && wr_q != 16'hFFFF) wr_q <= wr_q + 16'd1;
          stall_q     <= (access && waitrequest) ? stall_q + 32'd1 : 32'd0;
          addr_prev_q <= address;
          if (!active) result_v0_q <= register_v0;
          if (run_err_d != 3'd0) begin
            state_q    <= ST_FAIL;
            done_q     <= 1'b1;
            fail_q     <= 1'b1;
            err_code_q <= run_err_d;
            err_addr_q <= address;
          end else if (!active) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            pass_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cpu_reset   = cpu_reset_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign err_code    = err_code_q;
  assign err_addr    = err_addr_q;
  assign cycle_count = cycle_count_q;
  assign rd_count    = rd_q;
  assign wr_count    = wr_q;
  assign result_v0   = result_v0_q;

endmodule

// File: doc/mips_bus_monitor.md
MIPS_BUS_MONITOR -- requirements
Module: mips_bus_monitor

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- TIMEOUT_CYCLES, 1000, max RUN cycles before timeout
- RESET_CYCLES, 1, cycles cpu_reset held after reset release
- ACTIVE_WAIT, 1, cycles allowed for active to rise after cpu_reset falls
- WIN0_BASE, 32'hBFC00000, window 0 base address
- WIN0_SIZE, 32'h00008000, window 0 size in bytes
- WIN1_BASE, 32'h00000000, window 1 base address
- WIN1_SIZE, 0, window 1 size; 0 disables it
- ALLOW_NULL, 1, address 0 exempt from range check
- MAX_STALL, 64, max consecutive waitrequest cycles per transfer
- CHECK_V0, 0, enable final v0 comparison
- EXPECT_V0, 32'h0, expected final v0
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_reset  out  1  reset driven to CPU
- active  in  1  CPU active flag
- address  in  32  CPU bus byte address
- read  in  1  read request
- write  in  1  write request
- waitrequest  in  1  slave stall
- byteenable  in  4  lane enables
- register_v0  in  32  CPU v0 value
- done  out  1  run ended (pass or fail)
- pass  out  1  run passed
- fail  out  1  run failed
- err_code  out  3  first error cause
- err_addr  out  32  address sampled at first error
- cycle_count  out  32  RUN cycles elapsed
- rd_count  out  16  accepted reads, saturating
- wr_count  out  16  accepted writes, saturating
- result_v0  out  32  v0 latched at end of run

Function
REQ-003 SHALL implement FSM RST_SEQ -> WAIT_ACT -> RUN -> DONE | FAIL; DONE and FAIL are sticky until reset.
REQ-004 RST_SEQ SHALL hold cpu_reset=1 for exactly RESET_CYCLES clocks after reset deasserts, then enter WAIT_ACT with cpu_reset=0.
REQ-005 WAIT_ACT SHALL enter RUN when active=1; if active stays 0 for ACTIVE_WAIT cycles, it SHALL enter FAIL with err_code=1.
REQ-006 An access is any RUN cycle with read|write=1; it is legal iff address is in [WIN0_BASE, WIN0_BASE+WIN0_SIZE-1], or in the enabled window 1, or address==0 with ALLOW_NULL=1.
REQ-007 Error codes: 1 no-active, 2 out-of-range, 3 read&write both high, 4 byteenable==0 on access, 5 stall exceeds MAX_STALL or request dropped/address changed while waitrequest=1, 6 timeout, 7 v0 mismatch.
REQ-008 Errors detected in the same cycle SHALL resolve to the lowest code; only the first error is latched.
REQ-009 On error, fail, done and err_code SHALL be registered the next cycle, with err_addr = address sampled in the offending cycle.
REQ-010 The stall counter SHALL count consecutive access cycles with waitrequest=1, clear when waitrequest=0, and flag code 5 on reaching MAX_STALL+1.
REQ-011 rd_count/wr_count SHALL increment on read/write with waitrequest=0 in RUN and saturate at 16'hFFFF.
REQ-012 cycle_count SHALL increment every RUN cycle; when it reaches TIMEOUT_CYCLES with active=1, FSM SHALL enter FAIL with code 6.
REQ-013 When active=0 in RUN, result_v0 SHALL latch register_v0 and FSM SHALL go to DONE with pass=1, unless CHECK_V0=1 and register_v0!=EXPECT_V0, which goes to FAIL with code 7.
REQ-014 If active falls in the same cycle as an access error, the access error SHALL win.
REQ-015 In DONE/FAIL, counters and all outputs SHALL freeze and cpu_reset SHALL stay 0.

Reset
REQ-016 Reset SHALL asynchronously force state RST_SEQ, cpu_reset=1, and done, pass, fail, err_code, err_addr, cycle_count, rd_count, wr_count, result_v0 all 0.
REQ-017 Reset asserted mid-RUN/DONE/FAIL SHALL restart the full sequence, discarding prior results.

Verification
REQ-018 Reset, active rises 1 cycle after cpu_reset falls, 3 reads + 2 writes in WIN0, then active=0 with v0=32'h5 -> done=1, pass=1, rd_count=3, wr_count=2, result_v0=32'h5.
REQ-019 Read at address 32'hBFC08000 -> fail=1, err_code=2, err_addr=32'hBFC08000 the next cycle.
REQ-020 active never rises -> fail=1, err_code=1 after ACTIVE_WAIT cycles.
REQ-021 waitrequest held 65 cycles on a read with MAX_STALL=64 -> err_code=5; with address changing mid-stall -> err_code=5 immediately.
REQ-022 active held high with TIMEOUT_CYCLES=20 -> err_code=6 when cycle_count=20; with CHECK_V0=1, EXPECT_V0=7 and final v0=6 -> err_code=7.
REQ-023 Reset pulse while in FAIL -> all outputs 0, cpu_reset=1, and the sequence reruns cleanly.
